p_hit_t_seq: RTL and testbench
==============================

Name: p_hit_t_seq

Overview:
- Computes the ray/plane hit parameter t = (n·v0 − n·origin) / (n·dir) for one ray–triangle pair per transaction, in Q-format fixed point.
- Successor to the two-input-port p_hit datapath:
  - one shared input handshake;
  - a sequential radix-2 divider in place of a combinational divide;
  - parallel-ray, behind-origin and saturation classification;
  - a parametrised-depth output FIFO.
- Sits between the triangle/ray fetch FIFOs and the barycentric inside-test stage.

Parameters:
- D_BITS, 32, data word width (signed, two's complement).
- Q_BITS, 16, fractional bits.
- OUT_DEPTH, 4, output FIFO entries (power of 2, ≥2).
- EPS_Q, 0, parallel threshold: |n·dir| ≤ EPS_Q is treated as parallel.
- T_MIN_Q, 0, minimum accepted t; a hit requires t > T_MIN_Q.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low.
- tri_normal  in  D_BITS×[2:0]  plane normal n.
- v0  in  D_BITS×[2:0]  triangle vertex 0.
- origin  in  D_BITS×[2:0]  ray origin.
- dir  in  D_BITS×[2:0]  ray direction.
- in_empty  in  1  upstream first-word-fall-through FIFO empty.
- in_rd_en  out  1  pop of the upstream FIFO; operands are sampled in the same cycle.
- out_t  out  D_BITS  t of the head output entry.
- out_hit  out  1  head entry is a valid forward hit.
- out_parallel  out  1  head entry: ray is parallel to the plane.
- out_sat  out  1  head entry: t was saturated.
- out_empty  out  1  output FIFO empty.
- out_rd_en  in  1  pop of the output FIFO (first-word-fall-through).
- busy  out  1  FSM is not in IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE and the output FIFO is emptied.
  - out_empty=1, in_rd_en=0, busy=0; out_t/out_hit/out_parallel/out_sat = 0.
  - An in-flight transaction is discarded.
- FSM: IDLE → MUL → SUM → DIV → WRITE → IDLE.
  - The parallel case goes SUM → WRITE directly.
- IDLE:
  - in_rd_en = !in_empty && (fifo_count < OUT_DEPTH). It is combinational and asserted for one cycle only.
  - The twelve operands are registered on that edge and the FSM moves to MUL.
  - in_rd_en is never asserted outside IDLE.
- MUL:
  - d_i = v0_i − origin_i, computed at D_BITS+1 bits.
  - Registers the six products n_i·d_i and n_i·dir_i at full width.
- SUM:
  - num = (Σ n_i·d_i) >>> Q_BITS; den = (Σ n_i·dir_i) >>> Q_BITS.
  - Each sum is saturated to signed D_BITS.
  - Latches sign = num[MSB] ^ den[MSB], |num| and |den|.
  - If |den| ≤ EPS_Q: parallel=1, t = 2^(D_BITS−1)−1, go to WRITE.
  - Otherwise load the divider and go to DIV.
- DIV:
  - Restoring unsigned division of (|num| << Q_BITS) by |den|, one quotient bit per cycle.
  - DIV_ITERS = D_BITS+Q_BITS cycles.
  - Quotient magnitude ≥ 2^(D_BITS−1) saturates to max (or min when negative) and sets sat=1.
  - Otherwise t = sign ? −q : q.
  - Division truncates toward zero.
- WRITE:
  - Pushes {t, hit, parallel, sat} into the output FIFO.
  - hit = !parallel && (t > T_MIN_Q).
  - Returns to IDLE.
  - The FIFO can never be full here, because admission was reserved in IDLE.
- Latency from in_rd_en cycle (cycle 0) to out_empty low:
  - normal path: DIV_ITERS+4 cycles (52 for defaults);
  - parallel path: 4 cycles.
- Throughput is one transaction per DIV_ITERS+4 cycles; there is no overlap.
- Output FIFO:
  - A simultaneous push (WRITE) and pop (out_rd_en with !out_empty) in the same cycle keeps the count unchanged.
  - out_rd_en while empty is ignored.
  - Pointers wrap modulo OUT_DEPTH.
- busy = 1 in MUL, SUM, DIV and WRITE.

Decomposition:
- Package p_hit_pkg holds:
  - the FSM state enum (IDLE, MUL, SUM, DIV, WRITE);
  - a saturate-to-D_BITS function;
  - a result-flag struct {hit, parallel, sat}.
- Sub-module p_hit_seq_div:
  - parametrised iterative restoring divider;
  - interface: start, dividend, divisor, done, quotient, overflow;
  - reusable by the barycentric stage.
- The output FIFO is an instance of the existing fifo_array, with the data width widened to carry the flags.

Test Plan (Q16.16 unless stated):
- Forward hit: n=(0,0,1.0), v0=(0,0,5.0), origin=0, dir=(0,0,1.0) → out_t=0x00050000, hit=1, parallel=0, sat=0; out_empty falls 52 cycles after in_rd_en.
- Fractional quotient: v0=(0,0,1.0), dir=(0,0,3.0), n and origin as above → out_t=0x00005555, hit=1.
- Negative t: dir=(0,0,−1.0), other operands as in the forward-hit case → out_t=0xFFFB0000, hit=0, parallel=0.
- Parallel: dir=(1.0,0,0) → out_t=0x7FFFFFFF, parallel=1, hit=0; out_empty falls 4 cycles after in_rd_en.
  - Repeat with EPS_Q=0x10 and dir=(0,0,0x8) → parallel=1.
- Saturation: dir=(0,0,0x00000002) raw, v0=(0,0,5.0) → out_t=0x7FFFFFFF, sat=1, hit=1.
- Backpressure and reset:
  - Setup: OUT_DEPTH=2, out_rd_en=0, three inputs queued.
  - Expect: exactly two pops upstream; in_rd_en stays 0 with in_empty=0 and busy=0.
  - One out_rd_en pulse → the third input is accepted next cycle.
  - Then assert reset during DIV → out_empty=1 and busy=0 immediately, and no stale result appears after reset is released.

Source files
------------

// File: rtl/p_hit_pkg.sv
// Shared types and helpers for the sequential ray/plane hit-parameter stage.
package p_hit_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    SUM,
    DIV,
    WRITE
  } state_t;

  typedef struct packed {
    logic hit;
    logic parallel;
    logic sat;
  } flags_t;

  localparam int unsigned SAT_W = 128;

  // Clamp a wide signed value into the signed range of 'bits' bits (bits <= SAT_W).
  function automatic logic signed [SAT_W-1:0] sat_signed(
    input logic signed [SAT_W-1:0] x,
    input int unsigned             bits
  );
    logic signed [SAT_W-1:0] lo;
    logic signed [SAT_W-1:0] hi;
    lo = '1;
    lo = lo <<< (bits - 1);
    hi = ~lo;
    if (x > hi) begin
      return hi;
    end else if (x < lo) begin
      return lo;
    end else begin
      return x;
    end
  endfunction

endpackage

// File: rtl/fifo_array.sv
// Register-array FIFO with first-word-fall-through read and an occupancy count.
module fifo_array #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             push;
  logic             pop;

  assign empty   = (count == '0);
  assign full    = (count == ($clog2(DEPTH)+1)'(DEPTH));
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/p_hit_seq_div.sv
// Iterative restoring unsigned divider, one quotient bit per clock.
module p_hit_seq_div #(
  parameter int unsigned N_BITS   = 48,
  parameter int unsigned M_BITS   = 32,
  parameter int unsigned OUT_BITS = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [N_BITS-1:0]   dividend,
  input  logic [M_BITS-1:0]   divisor,
  output logic                done,
  output logic [OUT_BITS-1:0] quotient,
  output logic                overflow
);

  localparam int unsigned CNT_W = $clog2(N_BITS + 1);

  logic [N_BITS-1:0] q_r;
  logic [M_BITS-1:0] rem_r;
  logic [M_BITS-1:0] dvs_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [M_BITS:0]   trial;
  logic              trial_ge;

  always_comb begin
    trial    = {rem_r, q_r[N_BITS-1]};
    trial_ge = (trial >= {1'b0, dvs_r});
  end

  // The dividend shifts out of q_r as quotient bits shift in.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q_r   <= '0;
      rem_r <= '0;
      dvs_r <= '0;
      cnt_r <= '0;
    end else if (start) begin
      q_r   <= dividend;
      rem_r <= '0;
      dvs_r <= divisor;
      cnt_r <= CNT_W'(N_BITS);
    end else if (cnt_r != '0) begin
      rem_r <= trial_ge ? M_BITS'(trial - {1'b0, dvs_r}) : trial[M_BITS-1:0];
      q_r   <= {q_r[N_BITS-2:0], trial_ge};
      cnt_r <= cnt_r - 1'b1;
    end
  end

  // done flags the final iteration; quotient/overflow hold from the next cycle until restart.
  assign done     = (cnt_r == CNT_W'(1));
  assign quotient = q_r[OUT_BITS-1:0];
  assign overflow = |q_r[N_BITS-1:OUT_BITS-1];

endmodule

// File: rtl/p_hit_t_seq.sv
// Sequential ray/plane hit parameter t = n.(v0 - origin) / n.dir in Q fixed point.
module p_hit_t_seq
  import p_hit_pkg::*;
#(
  parameter int unsigned              D_BITS    = 32,
  parameter int unsigned              Q_BITS    = 16,
  parameter int unsigned              OUT_DEPTH = 4,
  parameter logic [D_BITS-1:0]        EPS_Q     = '0,
  parameter logic signed [D_BITS-1:0] T_MIN_Q   = '0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [2:0][D_BITS-1:0] tri_normal,
  input  logic [2:0][D_BITS-1:0] v0,
  input  logic [2:0][D_BITS-1:0] origin,
  input  logic [2:0][D_BITS-1:0] dir,
  input  logic                   in_empty,
  output logic                   in_rd_en,
  output logic [D_BITS-1:0]      out_t,
  output logic                   out_hit,
  output logic                   out_parallel,
  output logic                   out_sat,
  output logic                   out_empty,
  input  logic                   out_rd_en,
  output logic                   busy
);

  localparam int unsigned DIV_ITERS = D_BITS + Q_BITS;
  localparam int unsigned PW        = 2 * D_BITS + 1;
  localparam int unsigned NW        = 2 * D_BITS;
  localparam int unsigned SW        = PW + 2;
  localparam int unsigned FW        = D_BITS + $bits(flags_t);
  localparam int unsigned CW        = $clog2(OUT_DEPTH) + 1;
  localparam logic [D_BITS-1:0] T_MAX = {1'b0, {(D_BITS-1){1'b1}}};
  localparam logic [D_BITS-1:0] T_MIN = {1'b1, {(D_BITS-1){1'b0}}};

  state_t                   state;
  logic signed [D_BITS-1:0] n_r   [3];
  logic signed [D_BITS-1:0] v0_r  [3];
  logic signed [D_BITS-1:0] org_r [3];
  logic signed [D_BITS-1:0] dir_r [3];
  logic signed [D_BITS:0]   d_c   [3];
  logic signed [PW-1:0]     p_nd_r   [3];
  logic signed [NW-1:0]     p_ndir_r [3];
  logic signed [SW-1:0]     sum_nd;
  logic signed [SW-1:0]     sum_ndir;
  logic signed [D_BITS-1:0] num_c;
  logic signed [D_BITS-1:0] den_c;
  logic [D_BITS-1:0]        num_abs;
  logic [D_BITS-1:0]        den_abs;
  logic                     parallel_c;
  logic                     sign_r;
  logic                     par_r;
  logic                     div_start;
  logic                     div_done;
  logic                     div_ovf;
  logic [D_BITS-1:0]        div_q;
  logic [D_BITS-1:0]        t_w;
  flags_t                   flags_w;
  logic [FW-1:0]            head;
  logic [CW-1:0]            fifo_count;
  logic                     push;

  // Admission reserves a FIFO slot, so WRITE never meets a full FIFO.
  assign in_rd_en = reset && (state == IDLE) && !in_empty && (fifo_count < CW'(OUT_DEPTH));
  assign busy     = (state != IDLE);

  always_comb begin
    for (int unsigned i = 0; i < 3; i++) begin
      d_c[i] = (D_BITS+1)'(v0_r[i]) - (D_BITS+1)'(org_r[i]);
    end
    sum_nd     = SW'(p_nd_r[0]) + SW'(p_nd_r[1]) + SW'(p_nd_r[2]);
    sum_ndir   = SW'(p_ndir_r[0]) + SW'(p_ndir_r[1]) + SW'(p_ndir_r[2]);
    num_c      = D_BITS'(sat_signed(SAT_W'(sum_nd >>> Q_BITS), D_BITS));
    den_c      = D_BITS'(sat_signed(SAT_W'(sum_ndir >>> Q_BITS), D_BITS));
    num_abs    = num_c[D_BITS-1] ? D_BITS'(0) - num_c : num_c;
    den_abs    = den_c[D_BITS-1] ? D_BITS'(0) - den_c : den_c;
    parallel_c = (den_abs <= EPS_Q);
  end

  assign div_start = (state == SUM) && !parallel_c;

  p_hit_seq_div #(
    .N_BITS   (DIV_ITERS),
    .M_BITS   (D_BITS),
    .OUT_BITS (D_BITS)
  ) u_div (
    .clock    (clock),
    .reset    (reset),
    .start    (div_start),
    .dividend ({num_abs, {Q_BITS{1'b0}}}),
    .divisor  (den_abs),
    .done     (div_done),
    .quotient (div_q),
    .overflow (div_ovf)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      sign_r <= 1'b0;
      par_r  <= 1'b0;
      for (int unsigned i = 0; i < 3; i++) begin
        n_r[i]      <= '0;
        v0_r[i]     <= '0;
        org_r[i]    <= '0;
        dir_r[i]    <= '0;
        p_nd_r[i]   <= '0;
        p_ndir_r[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (in_rd_en) begin
            for (int unsigned i = 0; i < 3; i++) begin
              n_r[i]   <= tri_normal[i];
              v0_r[i]  <= v0[i];
              org_r[i] <= origin[i];
              dir_r[i] <= dir[i];
            end
            state <= MUL;
          end
        end
        MUL: begin
          for (int unsigned i = 0; i < 3; i++) begin
            p_nd_r[i]   <= PW'(n_r[i]) * PW'(d_c[i]);
            p_ndir_r[i] <= NW'(n_r[i]) * NW'(dir_r[i]);
          end
          state <= SUM;
        end
        SUM: begin
          sign_r <= num_c[D_BITS-1] ^ den_c[D_BITS-1];
          par_r  <= parallel_c;
          state  <= parallel_c ? WRITE : DIV;
        end
        DIV: begin
          if (div_done) begin
            state <= WRITE;
          end
        end
        WRITE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    if (par_r) begin
      t_w = T_MAX;
    end else if (div_ovf) begin
      t_w = sign_r ? T_MIN : T_MAX;
    end else begin
      t_w = sign_r ? D_BITS'(0) - div_q : div_q;
    end
    flags_w.parallel = par_r;
    flags_w.sat      = !par_r && div_ovf;
    flags_w.hit      = !par_r && ($signed(t_w) > T_MIN_Q);
  end

  assign push = (state == WRITE);

  fifo_array #(
    .WIDTH (FW),
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (push),
    .wr_data ({t_w, flags_w}),
    .rd_en   (out_rd_en),
    .rd_data (head),
    .empty   (out_empty),
    .count   (fifo_count)
  );

  // Stale array contents stay hidden while the FIFO is empty.
  assign {out_t, out_hit, out_parallel, out_sat} = out_empty ? '0 : head;

endmodule

// File: tb/tb_p_hit_t_seq.sv
// Directed scoreboard bench for p_hit_t_seq: default instance plus a shallow-FIFO/epsilon instance.
module tb_p_hit_t_seq;

  typedef struct {
    logic [31:0] t;
    logic        hit;
    logic        par;
    logic        sat;
  } exp_t;

  localparam logic [31:0] ONE = 32'h0001_0000;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [2:0][31:0] tri_normal, v0, origin, dir;

  logic in_empty_a, in_rd_en_a, out_hit_a, out_par_a, out_sat_a, out_empty_a, out_rd_en_a, busy_a;
  logic in_empty_b, in_rd_en_b, out_hit_b, out_par_b, out_sat_b, out_empty_b, out_rd_en_b, busy_b;
  logic [31:0] out_t_a, out_t_b;

  int   checks = 0;
  int   errors = 0;
  int   pops_b = 0;
  exp_t sb[$];

  always #5 clock = ~clock;

  always @(posedge clock) if (in_rd_en_b) pops_b++;

  p_hit_t_seq u_dut_a (
    .clock(clock), .reset(reset),
    .tri_normal(tri_normal), .v0(v0), .origin(origin), .dir(dir),
    .in_empty(in_empty_a), .in_rd_en(in_rd_en_a),
    .out_t(out_t_a), .out_hit(out_hit_a), .out_parallel(out_par_a), .out_sat(out_sat_a),
    .out_empty(out_empty_a), .out_rd_en(out_rd_en_a), .busy(busy_a)
  );

  p_hit_t_seq #(.OUT_DEPTH(2), .EPS_Q(32'h10)) u_dut_b (
    .clock(clock), .reset(reset),
    .tri_normal(tri_normal), .v0(v0), .origin(origin), .dir(dir),
    .in_empty(in_empty_b), .in_rd_en(in_rd_en_b),
    .out_t(out_t_b), .out_hit(out_hit_b), .out_parallel(out_par_b), .out_sat(out_sat_b),
    .out_empty(out_empty_b), .out_rd_en(out_rd_en_b), .busy(busy_b)
  );

  function automatic logic [2:0][31:0] vec(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return {z, y, x};
  endfunction

  function automatic exp_t mk(input logic [31:0] t, input logic h, input logic p, input logic s);
    exp_t e;
    e.t = t; e.hit = h; e.par = p; e.sat = s;
    return e;
  endfunction

  function automatic logic o_rd(input bit b);    return b ? in_rd_en_b : in_rd_en_a;   endfunction
  function automatic logic o_busy(input bit b);  return b ? busy_b : busy_a;           endfunction
  function automatic logic o_empty(input bit b); return b ? out_empty_b : out_empty_a; endfunction
  function automatic logic [31:0] o_t(input bit b); return b ? out_t_b : out_t_a;      endfunction
  function automatic logic o_hit(input bit b);   return b ? out_hit_b : out_hit_a;     endfunction
  function automatic logic o_par(input bit b);   return b ? out_par_b : out_par_a;     endfunction
  function automatic logic o_sat(input bit b);   return b ? out_sat_b : out_sat_a;     endfunction

  task automatic set_in_empty(input bit b, input logic v);
    if (b) in_empty_b = v; else in_empty_a = v;
  endtask

  task automatic set_out_rd(input bit b, input logic v);
    if (b) out_rd_en_b = v; else out_rd_en_a = v;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Offer one operand set; returns at the negedge of cycle 1 (the MUL cycle).
  task automatic issue(input bit b, input logic [2:0][31:0] n, input logic [2:0][31:0] vv,
                       input logic [2:0][31:0] oo, input logic [2:0][31:0] dd, input exp_t e);
    int w;
    tri_normal = n; v0 = vv; origin = oo; dir = dd;
    set_in_empty(b, 1'b0);
    w = 0;
    #1;
    while (!o_rd(b) && w < 200) begin
      @(negedge clock); #1; w++;
    end
    chk("accept", 32'(o_rd(b)), 32'd1);
    @(negedge clock);
    chk("rd_one_cycle", 32'(o_rd(b)), 32'd0);
    chk("busy_mul", 32'(o_busy(b)), 32'd1);
    set_in_empty(b, 1'b1);
    sb.push_back(e);
  endtask

  task automatic latency(input bit b, input int exp_lat, input string tag);
    int lat;
    lat = 1;
    while (o_empty(b) && lat < 200) begin
      @(negedge clock); lat++;
    end
    chk(tag, 32'(lat), 32'(exp_lat));
  endtask

  task automatic compare_head(input bit b, input string tag);
    exp_t e;
    e = sb.pop_front();
    chk({tag, "_valid"}, 32'(o_empty(b)), 32'd0);
    chk({tag, "_t"}, o_t(b), e.t);
    chk({tag, "_hit"}, 32'(o_hit(b)), 32'(e.hit));
    chk({tag, "_par"}, 32'(o_par(b)), 32'(e.par));
    chk({tag, "_sat"}, 32'(o_sat(b)), 32'(e.sat));
  endtask

  task automatic drain(input bit b, input string tag);
    int w;
    w = 0;
    while (o_empty(b) && w < 200) begin
      @(negedge clock); w++;
    end
    compare_head(b, tag);
    set_out_rd(b, 1'b1);
    @(negedge clock);
    set_out_rd(b, 1'b0);
  endtask

  initial begin
    int w;
    logic [2:0][31:0] nz, zero;
    nz   = vec(32'h0, 32'h0, ONE);
    zero = vec(32'h0, 32'h0, 32'h0);
    tri_normal = nz; v0 = zero; origin = zero; dir = zero;
    in_empty_a = 1'b0; in_empty_b = 1'b1;
    out_rd_en_a = 1'b0; out_rd_en_b = 1'b0;

    #2 reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_empty", 32'(out_empty_a), 32'd1);
    chk("rst_in_rd_en", 32'(in_rd_en_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_t", out_t_a, 32'd0);
    chk("rst_flags", {29'd0, out_hit_a, out_par_a, out_sat_a}, 32'd0);
    in_empty_a = 1'b1;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    issue(0, nz, vec(0, 0, 32'h0005_0000), zero, vec(0, 0, ONE), mk(32'h0005_0000, 1, 0, 0));
    latency(0, 52, "lat_normal");
    drain(0, "fwd");

    issue(0, nz, vec(0, 0, ONE), zero, vec(0, 0, 32'h0003_0000), mk(32'h0000_5555, 1, 0, 0));
    drain(0, "frac");
    issue(0, nz, vec(0, 0, 32'h0005_0000), zero, vec(0, 0, 32'hFFFF_0000), mk(32'hFFFB_0000, 0, 0, 0));
    drain(0, "neg");
    issue(0, nz, vec(0, 0, ONE), zero, vec(0, 0, 32'hFFFD_0000), mk(32'hFFFF_AAAB, 0, 0, 0));
    drain(0, "neg_frac");
    issue(0, nz, vec(0, 0, 32'hFFFB_0000), zero, vec(0, 0, 32'hFFFF_0000), mk(32'h0005_0000, 1, 0, 0));
    drain(0, "neg_neg");
    issue(0, nz, vec(0, 0, 32'h0005_0000), vec(0, 0, 32'h0002_0000), vec(0, 0, ONE), mk(32'h0003_0000, 1, 0, 0));
    drain(0, "origin");
    issue(0, nz, zero, zero, vec(0, 0, ONE), mk(32'h0, 0, 0, 0));
    drain(0, "t_zero");
    issue(0, nz, vec(0, 0, 32'h0005_0000), zero, vec(0, 0, 32'h2), mk(32'h7FFF_FFFF, 1, 0, 1));
    drain(0, "sat_pos");
    issue(0, nz, vec(0, 0, 32'h0005_0000), zero, vec(0, 0, 32'hFFFF_FFFE), mk(32'h8000_0000, 0, 0, 1));
    drain(0, "sat_neg");

    issue(0, nz, vec(0, 0, 32'h0005_0000), zero, vec(ONE, 0, 0), mk(32'h7FFF_FFFF, 0, 1, 0));
    latency(0, 4, "lat_parallel");
    drain(0, "parallel");

    issue(0, nz, vec(0, 0, 32'h0005_0000), zero, vec(0, 0, ONE), mk(32'h0005_0000, 1, 0, 0));
    issue(0, nz, vec(0, 0, 32'h0005_0000), zero, vec(0, 0, 32'hFFFF_0000), mk(32'hFFFB_0000, 0, 0, 0));
    drain(0, "order0");
    drain(0, "order1");
    chk("order_empty", 32'(out_empty_a), 32'd1);

    issue(1, nz, vec(0, 0, 32'h0005_0000), zero, vec(0, 0, 32'h8), mk(32'h7FFF_FFFF, 0, 1, 0));
    drain(1, "eps8");
    issue(1, nz, vec(0, 0, 32'h0005_0000), zero, vec(0, 0, 32'h10), mk(32'h7FFF_FFFF, 0, 1, 0));
    drain(1, "eps_edge");
    issue(1, nz, vec(0, 0, 32'h0005_0000), zero, vec(0, 0, 32'h11), mk(32'h4B4B_4B4B, 1, 0, 0));
    drain(1, "eps_over");

    // Backpressure: depth-2 FIFO with three inputs waiting upstream.
    pops_b = 0;
    tri_normal = nz; v0 = vec(0, 0, 32'h0005_0000); origin = zero; dir = vec(0, 0, ONE);
    in_empty_b = 1'b0;
    w = 0;
    while (pops_b < 2 && w < 300) begin @(negedge clock); w++; end
    w = 0;
    while (busy_b && w < 200) begin @(negedge clock); w++; end
    repeat (5) @(negedge clock);
    sb.push_back(mk(32'h0005_0000, 1, 0, 0));
    sb.push_back(mk(32'h0005_0000, 1, 0, 0));
    chk("bp_pops", 32'(pops_b), 32'd2);
    chk("bp_in_rd_en", 32'(in_rd_en_b), 32'd0);
    chk("bp_busy", 32'(busy_b), 32'd0);
    compare_head(1, "bp_head");
    out_rd_en_b = 1'b1;
    @(negedge clock);
    chk("bp_accept", 32'(in_rd_en_b), 32'd1);
    out_rd_en_b = 1'b0;
    @(negedge clock);
    in_empty_b = 1'b1;
    sb.push_back(mk(32'h0005_0000, 1, 0, 0));
    chk("bp_pops3", 32'(pops_b), 32'd3);

    repeat (10) @(negedge clock);
    chk("div_busy", 32'(busy_b), 32'd1);
    reset = 1'b0;
    #1;
    chk("rst_mid_empty", 32'(out_empty_b), 32'd1);
    chk("rst_mid_busy", 32'(busy_b), 32'd0);
    chk("rst_mid_t", out_t_b, 32'd0);
    sb.delete();
    @(negedge clock);
    reset = 1'b1;
    repeat (80) @(negedge clock);
    chk("no_stale_empty", 32'(out_empty_b), 32'd1);
    chk("no_stale_pops", 32'(pops_b), 32'd3);

    issue(1, nz, vec(0, 0, ONE), zero, vec(0, 0, 32'h0003_0000), mk(32'h0000_5555, 1, 0, 0));
    drain(1, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
